i_scan_ctrl: RTL and testbench

I_SCAN_CTRL -- requirements
Module: i_scan_ctrl

---
 rtl/i_scan_ctrl_if.sv | 25 ++
 rtl/i_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_i_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i_scan_ctrl_if.sv
// Request bus between the scan controller and the downstream pixel consumer.
// The controller (master) presents one pixel request at a time.
// The consumer (slave) accepts a request by driving req_ready.
interface i_scan_ctrl_if #(
  parameter int DIM_W  = 13,
  parameter int ADDR_W = 26
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic              line_end;
  logic              frame_end;

  modport master (
    output req_valid, req_addr, col, row, line_end, frame_end,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, col, row, line_end, frame_end,
    output req_ready
  );
endinterface

// File: rtl/i_scan_ctrl.sv
// Raster-scan address generator.
// After an accepted start it walks a width x height window in row-major order
// and issues one request per pixel, with valid/ready flow control.
// Each new line starts at the previous line start plus line_stride, so the
// address path needs no multiplier.
module i_scan_ctrl #(
  parameter int DIM_W  = 13,
  parameter int ADDR_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [ADDR_W-1:0] base_addr,
  i_scan_ctrl_if.master     req,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  // Common width used to compare a column count against an address stride.
  localparam int CW = (ADDR_W > DIM_W) ? ADDR_W : DIM_W;

  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_bad;
  logic              last_col;
  logic              last_row;
  logic              scanning;

  // A start is rejected for an empty window, or when the lines would overlap.
  always_comb begin
    cfg_bad = (img_width == '0) || (img_height == '0) ||
              (CW'(line_stride) < CW'(img_width));
  end

  // Position flags for the request currently being presented.
  always_comb begin
    scanning = (state_q == SCAN);
    last_col = (col_q == (width_q - ONE_D));
    last_row = (row_q == (height_q - ONE_D));
  end

  // Next-state and datapath: start handling, handshake stepping, abort.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    stride_d  = stride_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    line_d    = line_q;
    cfg_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = SCAN;
            width_d  = img_width;
            height_d = img_height;
            stride_d = line_stride;
            col_d    = '0;
            row_d    = '0;
            addr_d   = base_addr;
            line_d   = base_addr;
          end
        end
      end
      SCAN: begin
        // Abort wins over a simultaneous handshake; that request is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (req.req_ready) begin
          if (last_col && last_row) begin
            state_d = DONE;
          end else if (last_col) begin
            col_d  = '0;
            row_d  = row_q + ONE_D;
            addr_d = line_q + stride_q;
            line_d = line_q + stride_q;
          end else begin
            col_d  = col_q + ONE_D;
            addr_d = addr_q + ONE_A;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      stride_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      stride_q  <= stride_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Output decode: all outputs come straight from state, with no input paths.
  always_comb begin
    req.req_valid = scanning;
    req.req_addr  = addr_q;
    req.col       = col_q;
    req.row       = row_q;
    req.line_end  = scanning && last_col;
    req.frame_end = scanning && last_col && last_row;
    busy          = (state_q == SCAN) || (state_q == DONE);
    done          = (state_q == DONE);
    cfg_err       = cfg_err_q;
  end

endmodule

// File: tb/tb_i_scan_ctrl.sv
// Directed bench for i_scan_ctrl.
// An independent raster model pushes the expected requests into a queue.
// Each handshake pops the queue; stalled cycles compare against the head.
module tb_i_scan_ctrl;
  localparam int DIM_W  = 13;
  localparam int ADDR_W = 26;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic              le;
    logic              fe;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [DIM_W-1:0]  img_width, img_height;
  logic [ADDR_W-1:0] line_stride, base_addr;
  logic              busy, done, cfg_err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  i_scan_ctrl_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  i_scan_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .img_width  (img_width),
    .img_height (img_height),
    .line_stride(line_stride),
    .base_addr  (base_addr),
    .req        (bus),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference raster: addr = base + r*stride + c, modulo 2^ADDR_W.
  task automatic push_frame(input int w, input int h,
                            input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] b);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.addr = b + ADDR_W'(r) * s + ADDR_W'(c);
        e.col  = DIM_W'(c);
        e.row  = DIM_W'(r);
        e.le   = (c == w - 1);
        e.fe   = (c == w - 1) && (r == h - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Entered and left on a negedge. rmode 0: ready always high; 1: ready 1,0,0,1.
  // abort_hs: abort together with this handshake number (0 = never).
  task automatic scan(input int w, input int h,
                      input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] b,
                      input int rmode, input int abort_hs);
    exp_t e;
    int   hs, cyc, k;
    logic rdy, aborted;
    logic [3:0] pat;
    pat = 4'b1001;
    push_frame(w, h, s, b);
    img_width = DIM_W'(w); img_height = DIM_W'(h);
    line_stride = s; base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; cyc = 0; k = 0; aborted = 1'b0;
    while (sb.size() > 0 && cyc < 200 && !aborted) begin
      rdy = (rmode == 0) ? 1'b1 : pat[3 - (k % 4)];
      k++;
      e = sb[0];
      chk("req_valid", bus.req_valid, 1'b1);
      chk("busy_scan", busy, 1'b1);
      chk("req_addr", bus.req_addr, e.addr);
      chk("col", bus.col, e.col);
      chk("row", bus.row, e.row);
      chk("line_end", bus.line_end, e.le);
      chk("frame_end", bus.frame_end, e.fe);
      if (rdy) begin
        void'(sb.pop_front());
        hs++;
        if (hs == abort_hs) begin
          abort = 1'b1;
          aborted = 1'b1;
        end
      end
      bus.req_ready = rdy;
      @(negedge clk);
      abort = 1'b0;
      bus.req_ready = 1'b0;
      cyc++;
    end
    if (cyc >= 200) chk("scan_timeout", 1'b1, 1'b0);
    if (aborted) begin
      chk("abort_valid", bus.req_valid, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      sb.delete();
    end else begin
      chk("handshakes", 64'(hs), 64'(w * h));
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b1);
      chk("done_valid", bus.req_valid, 1'b0);
      @(negedge clk);
      chk("done_clear", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic bad_cfg(input int w, input int h, input logic [ADDR_W-1:0] s);
    img_width = DIM_W'(w); img_height = DIM_W'(h);
    line_stride = s; base_addr = 26'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1'b1);
    chk("cfg_err_valid", bus.req_valid, 1'b0);
    chk("cfg_err_busy", busy, 1'b0);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 1'b0);
    chk("cfg_err_valid2", bus.req_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b1; bus.req_ready = 1'b1;
    img_width = 13'd3; img_height = 13'd2; line_stride = 26'd4; base_addr = 26'd100;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_addr", bus.req_addr, '0);
    chk("rst_colrow", {bus.col, bus.row}, '0);
    rst = 1'b0; start = 1'b0; abort = 1'b0; bus.req_ready = 1'b0;
    @(negedge clk);

    // Full 3x2 frame, then a back-to-back start right after DONE.
    scan(3, 2, 26'd4, 26'd100, 0, 0);
    scan(3, 2, 26'd4, 26'd100, 1, 0);
    // Minimal frame.
    scan(1, 1, 26'd1, 26'd200, 0, 0);
    // Address wrap across 2^ADDR_W.
    scan(3, 2, 26'd5, 26'h3FFFFFE, 1, 0);
    // Rejected configs.
    bad_cfg(0, 2, 26'd4);
    bad_cfg(3, 0, 26'd4);
    bad_cfg(3, 2, 26'd2);
    // Abort on the 4th handshake, then restart.
    scan(3, 2, 26'd4, 26'd100, 0, 4);
    scan(2, 2, 26'd2, 26'd10, 0, 0);

    // Reset mid-frame at row=1, col=1.
    img_width = 13'd3; img_height = 13'd2; line_stride = 26'd4; base_addr = 26'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.req_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.req_ready = 1'b0;
    chk("pre_rst_col", bus.col, 13'd1);
    chk("pre_rst_row", bus.row, 13'd1);
    chk("pre_rst_addr", bus.req_addr, 26'd105);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.req_valid, 1'b0);
    chk("mid_rst_outs", {bus.req_addr, bus.col, bus.row, bus.line_end, bus.frame_end,
                         busy, done, cfg_err}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.req_valid, 1'b0);
    chk("post_rst_done", done, 1'b0);
    scan(3, 2, 26'd4, 26'd100, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
